// File: rtl/cpld_spi_responder_pkg.sv
// Shared constants, FSM encoding and read-mux helper for the CPLD SPI responder.
// Frames are 16 bits: R/W, 7-bit address, 8-bit data, MSB first.
package cpld_spi_responder_pkg;

    localparam int FRAME_BITS = 16;
    localparam int ADDR_BITS  = 8;
    localparam int CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [6:0] ADDR_ID      = 7'h00;
    localparam logic [6:0] ADDR_STATUS  = 7'h01;
    localparam logic [6:0] ADDR_CTRL    = 7'h02;
    localparam logic [6:0] ADDR_SCRATCH = 7'h03;
    localparam logic [6:0] ADDR_PULSE   = 7'h04;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA,
        DONE
    } state_e;

    // The pulse register and unmapped addresses read back as zero.
    function automatic logic [7:0] read_mux(
        input logic [6:0] addr,
        input logic [7:0] id_value,
        input logic [7:0] status,
        input logic [7:0] ctrl,
        input logic [7:0] scratch
    );
        case (addr)
            ADDR_ID:      return id_value;
            ADDR_STATUS:  return status;
            ADDR_CTRL:    return ctrl;
            ADDR_SCRATCH: return scratch;
            default:      return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/cpld_spi_responder_sync_edge_detect.sv
// Multi-stage synchroniser for the SPI pins; the edge input also gets rise/fall
// pulses derived from its last two synchronised samples.
module cpld_spi_responder_sync_edge_detect #(
    parameter int                 STAGES      = 2,
    parameter int                 N_LEVEL     = 2,
    parameter logic               EDGE_RESET  = 1'b0,
    parameter logic [N_LEVEL-1:0] LEVEL_RESET = '0
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               edge_in,
    input  logic [N_LEVEL-1:0] level_in,
    output logic               rise,
    output logic               fall,
    output logic [N_LEVEL-1:0] level_out
);

    logic [STAGES-1:0]              edge_sync_q, edge_sync_d;
    logic                           edge_prev_q, edge_prev_d;
    logic [STAGES-1:0][N_LEVEL-1:0] level_sync_q, level_sync_d;

    always_comb begin
        edge_sync_d  = {edge_sync_q[STAGES-2:0], edge_in};
        edge_prev_d  = edge_sync_q[STAGES-1];
        level_sync_d = {level_sync_q[STAGES-2:0], level_in};
    end

    // NOTE: state flops use non-blocking assignments so every flop samples
    // the pre-edge value of its neighbours, which is what makes this a chain.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            edge_sync_q  <= {STAGES{EDGE_RESET}};
            edge_prev_q  <= EDGE_RESET;
            level_sync_q <= {STAGES{LEVEL_RESET}};
        end else begin
            edge_sync_q  <= edge_sync_d;
            edge_prev_q  <= edge_prev_d;
            level_sync_q <= level_sync_d;
        end
    end

    assign rise      =  edge_sync_q[STAGES-1] & ~edge_prev_q;
    assign fall      = ~edge_sync_q[STAGES-1] &  edge_prev_q;
    assign level_out = level_sync_q[STAGES-1];

endmodule

// File: rtl/cpld_spi_responder.sv
// SPI mode-0 responder exposing CPLD status, control, scratch and pulse registers
// to the CPU; all logic runs on sysclk with SCLK/MOSI/CS oversampled.
module cpld_spi_responder
    import cpld_spi_responder_pkg::*;
#(
    parameter logic [7:0] ID_VALUE    = 8'hA5,
    parameter logic [7:0] CTRL_RESET  = 8'h00,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       sysclk,
    input  logic       reset,
    input  logic       spi_clk,
    input  logic       spi_mosi,
    input  logic       spi_cs_INV,
    output logic       spi_miso,
    input  logic [7:0] status_in,
    output logic [7:0] ctrl_out,
    output logic [7:0] pulse_out,
    output logic       wr_strobe
);

    logic       sclk_rise, sclk_fall;
    logic [1:0] level_s;
    logic       mosi_s, cs_n_s;

    // CS resets to the deasserted level so a reset never looks like a frame start.
    cpld_spi_responder_sync_edge_detect #(
        .STAGES     (SYNC_STAGES),
        .N_LEVEL    (2),
        .EDGE_RESET (1'b0),
        .LEVEL_RESET(2'b10)
    ) u_sync (
        .sysclk   (sysclk),
        .reset    (reset),
        .edge_in  (spi_clk),
        .level_in ({spi_cs_INV, spi_mosi}),
        .rise     (sclk_rise),
        .fall     (sclk_fall),
        .level_out(level_s)
    );

    assign mosi_s = level_s[0];
    assign cs_n_s = level_s[1];

    state_e           state_q, state_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [6:0]       shift_q, shift_d;
    logic             rw_q, rw_d;
    logic [6:0]       addr_q, addr_d;
    logic [7:0]       miso_sr_q, miso_sr_d;
    logic             miso_q, miso_d;
    logic [7:0]       ctrl_q, ctrl_d;
    logic [7:0]       scratch_q, scratch_d;
    logic [7:0]       pulse_q, pulse_d;
    logic             wr_strobe_q, wr_strobe_d;
    logic [7:0]       rx_byte;

    always_comb begin
        // NOTE: every _d starts from its _q (or its idle value) before any
        // branch, so no path through the case can infer a latch.
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        miso_sr_d   = miso_sr_q;
        miso_d      = miso_q;
        ctrl_d      = ctrl_q;
        scratch_d   = scratch_q;
        pulse_d     = 8'h00;
        wr_strobe_d = 1'b0;
        rx_byte     = {shift_q, mosi_s};

        if (cs_n_s) begin
            state_d   = IDLE;
            bit_cnt_d = '0;
            miso_d    = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    bit_cnt_d = '0;
                    miso_d    = 1'b0;
                    state_d   = ADDR;
                end
                ADDR: begin
                    if (sclk_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_W'(ADDR_BITS - 1)) begin
                            rw_d      = shift_q[6];
                            addr_d    = rx_byte[6:0];
                            miso_sr_d = read_mux(rx_byte[6:0], ID_VALUE, status_in,
                                                 ctrl_q, scratch_q);
                            state_d   = DATA;
                        end
                    end
                end
                DATA: begin
                    if (sclk_fall) begin
                        miso_d    = miso_sr_q[7];
                        miso_sr_d = {miso_sr_q[6:0], 1'b0};
                    end
                    if (sclk_rise) begin
                        shift_d   = rx_byte[6:0];
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        if (bit_cnt_q == CNT_W'(FRAME_BITS - 1)) begin
                            if (rw_q) begin
                                wr_strobe_d = 1'b1;
                                case (addr_q)
                                    ADDR_CTRL:    ctrl_d    = rx_byte;
                                    ADDR_SCRATCH: scratch_d = rx_byte;
                                    ADDR_PULSE:   pulse_d   = rx_byte;
                                    default:      ;
                                endcase
                            end
                            state_d = DONE;
                        end
                    end
                end
                DONE: begin
                    miso_d = 1'b0;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            miso_sr_q   <= '0;
            miso_q      <= 1'b0;
            ctrl_q      <= CTRL_RESET;
            scratch_q   <= 8'h00;
            pulse_q     <= 8'h00;
            wr_strobe_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            miso_sr_q   <= miso_sr_d;
            miso_q      <= miso_d;
            ctrl_q      <= ctrl_d;
            scratch_q   <= scratch_d;
            pulse_q     <= pulse_d;
            wr_strobe_q <= wr_strobe_d;
        end
    end

    assign spi_miso  = miso_q;
    assign ctrl_out  = ctrl_q;
    assign pulse_out = pulse_q;
    assign wr_strobe = wr_strobe_q;

endmodule
